// File: rtl/common_pkg.sv
// common_pkg: shared pipeline control struct, load/store funct3 codes and MEM-stage FSM states.
//   control_t   - control bundle carried from execute through to write-back
//   F3_*        - RV32I load/store funct3 encodings
//   mem_state_t - MEM-stage access FSM states
package common_pkg;
  typedef struct packed {
    logic       reg_write;
    logic [4:0] rd;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
  } control_t;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: combinational store lane formatting, load lane extraction/extension and misalignment check.
//   mem_read/mem_write/funct3/addr/data - current instruction, used for store formatting and the misalignment check
//   ld_funct3/ld_addr/rdata             - captured load funct3, captured address low bits and returned load data
//   be/wdata                            - store byte enables and lane-replicated store data
//   load                                - extended load result
//   bad                                 - access is misaligned or uses an unsupported funct3
module mem_align
  import common_pkg::*;
(
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load,
  output logic        bad
);
  logic       unsup;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    // funct3 3/6/7 are never valid; 4/5 (unsigned) exist only for loads
    unsup = funct3 == 3'd3 || (funct3[2] && (funct3[1] || mem_write));
    bad   = (mem_read || mem_write) &&
            (unsup || (funct3[1:0] == 2'd1 && addr[0]) || (funct3[1:0] == 2'd2 && addr != 2'd0));
    be    = funct3[1:0] == 2'd0 ? 4'b0001 << addr :
            funct3[1:0] == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = funct3[1:0] == 2'd0 ? {4{data[7:0]}} :
            funct3[1:0] == 2'd1 ? {2{data[15:0]}} : data;
    b     = rdata[{ld_addr, 3'b000} +: 8];
    h     = ld_addr[1] ? rdata[31:16] : rdata[15:0];
    load  = ld_funct3 == F3_LB  ? {{24{b[7]}}, b} :
            ld_funct3 == F3_LBU ? {24'b0, b} :
            ld_funct3 == F3_LH  ? {{16{h[15]}}, h} :
            ld_funct3 == F3_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: RV32I MEM stage; issues one data-memory access at a time over req/ack and registers the write-back result.
//   valid_in/alu_res/mem_data/control - instruction from execute
//   stall                             - hold upstream stages (combinational)
//   dmem_*                            - data-memory request bus
//   wb_valid/wb_data/wb_control       - registered write-back outputs
//   misaligned                        - one-cycle pulse when a bad access is dropped
module memory_stage
  import common_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_res,
  input  logic [31:0] mem_data,
  input  control_t    control,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output control_t    wb_control,
  output logic        misaligned
);
  mem_state_t  state;
  logic [31:0] cap_addr;
  logic [2:0]  cap_f3;
  control_t    cap_ctl;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load;
  logic        bad;
  logic        is_mem;
  mem_align u_align (
    .mem_read  (control.mem_read),
    .mem_write (control.mem_write),
    .funct3    (control.mem_funct3),
    .addr      (alu_res[1:0]),
    .data      (mem_data),
    .ld_funct3 (cap_f3),
    .ld_addr   (cap_addr[1:0]),
    .rdata     (dmem_rdata),
    .be        (be),
    .wdata     (wdata),
    .load      (load),
    .bad       (bad)
  );
  assign is_mem    = valid_in && (control.mem_read || control.mem_write);
  assign stall     = state == MEM_WAIT ? !dmem_ack : is_mem && !bad;
  assign dmem_addr = {cap_addr[31:2], 2'b00};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MEM_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      cap_addr   <= '0;
      cap_f3     <= '0;
      cap_ctl    <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_control <= '0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      if (state == MEM_IDLE) begin
        if (is_mem && !bad) begin
          state      <= MEM_WAIT;
          dmem_req   <= 1'b1;
          dmem_we    <= control.mem_write;
          dmem_be    <= control.mem_write ? be : 4'b0000;
          dmem_wdata <= wdata;
          cap_addr   <= alu_res;
          cap_f3     <= control.mem_funct3;
          cap_ctl    <= control;
          wb_valid   <= 1'b0;
        end else begin
          // a memory op reaching here was rejected as misaligned/unsupported
          wb_valid   <= valid_in && !is_mem;
          wb_data    <= alu_res;
          wb_control <= control;
          misaligned <= is_mem;
        end
      end else if (dmem_ack) begin
        state      <= MEM_IDLE;
        dmem_req   <= 1'b0;
        wb_valid   <= 1'b1;
        wb_control <= cap_ctl;
        wb_data    <= dmem_we ? cap_addr : load;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end
endmodule
